hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk_i (rising edge), rst_i (asserted 1 clears all state immediately).
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- id_reg1  in  5  ID rs1 index
- id_reg2  in  5  ID rs2 index
- id_re1  in  1  ID uses rs1
- id_re2  in  1  ID uses rs2
- ex_wr  in  5  EX destination
- ex_rf_we  in  1  EX writes RF
- ex_is_load  in  1  EX holds a load
- mem_wr  in  5  MEM destination
- mem_rf_we  in  1  MEM writes RF
- wb_wr  in  5  WB destination
- wb_rf_we  in  1  WB writes RF
- ex_br_taken  in  1  EX redirects PC
- mem_ready  in  1  DRAM access completes this cycle
- mem_is_mem  in  1  MEM holds load/store
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID
- stall_idex  out  1  hold ID/EX
- flush_ifid  out  1  clear IF/ID to bubble
- flush_idex  out  1  load bubble into ID/EX (have_inst=0, rf_we=0, dram_we=0)
- fwd1_sel  out  2  rs1 source: 00 RF, 01 EX, 10 MEM, 11 WB
- fwd2_sel  out  2  rs2 source, same encoding
- stall_cnt  out  32  stall cycles (macro only)
- flush_cnt  out  32  flush events (macro only)

Function
REQ-003 A source matches a stage when its enable is 1, the index is nonzero, and the index equals that stage's destination with rf_we=1; register 0 SHALL never match.
REQ-004 fwdN_sel SHALL pick the youngest match, in priority EX > MEM > WB; with no match, 00; fwdN_sel SHALL be combinational.
REQ-005 Load-use SHALL be flagged when ex_is_load=1 and either source matches EX.
REQ-006 The FSM SHALL have three states, RUN, LU_BUBBLE and MEM_WAIT; the state register is the only sequential control state.
REQ-007 In RUN, with no load-use and no wait: all stall/flush outputs are 0.
REQ-008 In RUN, on load-use (and ex_br_taken=0):
- assert stall_pc, stall_ifid and flush_idex for that cycle
- next state LU_BUBBLE
REQ-009 In LU_BUBBLE, all stall/flush outputs are 0 and forwarding from MEM resolves the operand; the next state is RUN. A second load-use SHALL NOT occur here, because the load has left EX.
REQ-010 In any state, mem_is_mem=1 with mem_ready=0 SHALL:
- assert stall_pc, stall_ifid and stall_idex
- freeze the FSM in MEM_WAIT (flush outputs 0)
- on mem_ready=1, return to RUN the following cycle
REQ-011 ex_br_taken=1 SHALL assert flush_ifid and flush_idex in the same cycle with stall_pc=0, overriding load-use; ex_br_taken SHALL be ignored while in MEM_WAIT.
REQ-012 Stall and flush outputs SHALL be combinational from the current state and inputs; there is zero-cycle latency from a hazard to the stall.
REQ-013 flush_ifid and stall_ifid SHALL never both be 1; flush takes priority.

Reset
REQ-014 While rst_i=1:
- state = RUN
- all stall/flush outputs 0
- fwd selects follow REQ-004
- counters 0
REQ-015 rst_i asserted mid-stall or mid-wait SHALL abandon the state immediately; the first cycle after release is RUN.

Configuration
REQ-016 With HAZARD_PERF_CNT_EN defined:
- stall_cnt increments by 1 each cycle stall_pc=1
- flush_cnt increments by 1 each cycle flush_ifid=1
- both wrap 0xFFFFFFFF -> 0
REQ-017 Without HAZARD_PERF_CNT_EN, stall_cnt and flush_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-018 RAW forward: ex_wr=5, ex_rf_we=1, id_reg1=5, id_re1=1 -> fwd1_sel=01, no stall.
REQ-019 Priority: EX, MEM and WB all write x7, id_reg2=7 -> fwd2_sel=01; clear EX -> 10; clear MEM -> 11; index 0 -> 00.
REQ-020 Load-use: ex_is_load=1, ex_wr=3, id_reg2=3 ->
- cycle N: stall_pc=stall_ifid=flush_idex=1
- cycle N+1: outputs 0, fwd2_sel=10
REQ-021 Branch vs. load-use in the same cycle -> flush_ifid=flush_idex=1, stall_pc=0, state stays RUN.
REQ-022 DRAM wait: mem_is_mem=1, mem_ready=0 for 3 cycles -> stalls held 3 cycles, then released the cycle after mem_ready=1; with the macro, stall_cnt=3.
REQ-023 Reset mid-LU_BUBBLE -> outputs 0 and counters 0 immediately; normal forwarding after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use bubble, DRAM wait and branch flush.
// Optional performance counters are built in when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_reg1,
  input  logic [4:0]  id_reg2,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  ex_wr,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_wr,
  input  logic        mem_rf_we,
  input  logic [4:0]  wb_wr,
  input  logic        wb_rf_we,
  input  logic        ex_br_taken,
  input  logic        mem_ready,
  input  logic        mem_is_mem,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StLuBubble, StMemWait} state_e;

  state_e state_q, state_d;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic src_match(logic en, logic [4:0] idx, logic [4:0] dst, logic we);
    return en && (idx != 5'd0) && we && (idx == dst);
  endfunction

  logic ex1, ex2, mem1, mem2, wb1, wb2;
  logic load_use, mem_wait;

  assign ex1  = src_match(id_re1, id_reg1, ex_wr,  ex_rf_we);
  assign ex2  = src_match(id_re2, id_reg2, ex_wr,  ex_rf_we);
  assign mem1 = src_match(id_re1, id_reg1, mem_wr, mem_rf_we);
  assign mem2 = src_match(id_re2, id_reg2, mem_wr, mem_rf_we);
  assign wb1  = src_match(id_re1, id_reg1, wb_wr,  wb_rf_we);
  assign wb2  = src_match(id_re2, id_reg2, wb_wr,  wb_rf_we);

  assign load_use = ex_is_load && (ex1 || ex2);
  assign mem_wait = mem_is_mem && !mem_ready;

  always_comb begin
    fwd1_sel = 2'b00;
    if (ex1)       fwd1_sel = 2'b01;
    else if (mem1) fwd1_sel = 2'b10;
    else if (wb1)  fwd1_sel = 2'b11;
    fwd2_sel = 2'b00;
    if (ex2)       fwd2_sel = 2'b01;
    else if (mem2) fwd2_sel = 2'b10;
    else if (wb2)  fwd2_sel = 2'b11;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StRun;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = StRun;
    if (mem_wait) begin
      state_d = StMemWait;
    end else if (state_q == StRun && !ex_br_taken && load_use) begin
      state_d = StLuBubble;
    end
  end

  // A DRAM wait freezes the whole front end, so it dominates branch and load-use handling.
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    stall_idex = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst_i) begin
      if (mem_wait) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
      end else if (state_q != StMemWait) begin
        if (ex_br_taken) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (state_q == StRun && load_use) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_pc)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ifid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change on the falling edge and are checked
// 1 time unit later, well away from the rising edge.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_reg1, id_reg2, ex_wr, mem_wr, wb_wr;
  logic        id_re1, id_re2, ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
  logic        ex_br_taken, mem_ready, mem_is_mem;
  logic        stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .id_reg1     (id_reg1),
    .id_reg2     (id_reg2),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .ex_wr       (ex_wr),
    .ex_rf_we    (ex_rf_we),
    .ex_is_load  (ex_is_load),
    .mem_wr      (mem_wr),
    .mem_rf_we   (mem_rf_we),
    .wb_wr       (wb_wr),
    .wb_rf_we    (wb_rf_we),
    .ex_br_taken (ex_br_taken),
    .mem_ready   (mem_ready),
    .mem_is_mem  (mem_is_mem),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .stall_idex  (stall_idex),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fwd1_sel    (fwd1_sel),
    .fwd2_sel    (fwd2_sel),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic clear_inputs();
    id_reg1 = 5'd0; id_reg2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wr = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0;
    mem_wr = 5'd0; mem_rf_we = 1'b0; wb_wr = 5'd0; wb_rf_we = 1'b0;
    ex_br_taken = 1'b0; mem_ready = 1'b1; mem_is_mem = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_wr = 5'd3; ex_rf_we = 1'b1; id_reg2 = 5'd3; id_re2 = 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] ctl;
    clear_inputs();
    rst_i = 1'b1;
    set_load_use();
    #1;
    ctl = {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex};
    checks++;
    if (ctl !== 5'b00000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 00000", ctl);
    end
    checks++;
    if (fwd2_sel !== 2'b01) begin
      errors++; $display("FAIL reset_fwd2: got %b expected 01", fwd2_sel);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_raw_forward();
    reset_dut();
    ex_wr = 5'd5; ex_rf_we = 1'b1; id_reg1 = 5'd5; id_re1 = 1'b1;
    #1;
    checks++;
    if (fwd1_sel !== 2'b01) begin
      errors++; $display("FAIL raw_fwd1: got %b expected 01", fwd1_sel);
    end
    checks++;
    if ({stall_pc, stall_ifid, flush_idex} !== 3'b000) begin
      errors++; $display("FAIL raw_nostall: got %b expected 000", {stall_pc, stall_ifid, flush_idex});
    end
  endtask

  task automatic test_priority();
    reset_dut();
    ex_wr = 5'd7; ex_rf_we = 1'b1; mem_wr = 5'd7; mem_rf_we = 1'b1;
    wb_wr = 5'd7; wb_rf_we = 1'b1; id_reg2 = 5'd7; id_re2 = 1'b1;
    #1;
    checks++;
    if (fwd2_sel !== 2'b01) begin
      errors++; $display("FAIL prio_ex: got %b expected 01", fwd2_sel);
    end
    ex_rf_we = 1'b0; #1;
    checks++;
    if (fwd2_sel !== 2'b10) begin
      errors++; $display("FAIL prio_mem: got %b expected 10", fwd2_sel);
    end
    mem_rf_we = 1'b0; #1;
    checks++;
    if (fwd2_sel !== 2'b11) begin
      errors++; $display("FAIL prio_wb: got %b expected 11", fwd2_sel);
    end
    ex_rf_we = 1'b1; mem_rf_we = 1'b1;
    ex_wr = 5'd0; mem_wr = 5'd0; wb_wr = 5'd0; id_reg2 = 5'd0; #1;
    checks++;
    if (fwd2_sel !== 2'b00) begin
      errors++; $display("FAIL prio_x0: got %b expected 00", fwd2_sel);
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    set_load_use();
    #1;
    checks++;
    if ({stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex} !== 5'b11001) begin
      errors++;
      $display("FAIL lu_cycle_n: got %b expected 11001",
               {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex});
    end
    @(negedge clk_i);
    // The load moved to MEM; EX now holds the bubble.
    ex_is_load = 1'b0; ex_rf_we = 1'b0; mem_wr = 5'd3; mem_rf_we = 1'b1;
    #1;
    checks++;
    if ({stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex} !== 5'b00000) begin
      errors++;
      $display("FAIL lu_cycle_n1: got %b expected 00000",
               {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex});
    end
    checks++;
    if (fwd2_sel !== 2'b10) begin
      errors++; $display("FAIL lu_fwd2: got %b expected 10", fwd2_sel);
    end
    checks++;
    if (stall_cnt !== (PerfEn ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, PerfEn ? 1 : 0);
    end
  endtask

  task automatic test_branch_vs_load_use();
    reset_dut();
    set_load_use();
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if ({stall_pc, stall_ifid, flush_ifid, flush_idex} !== 4'b0011) begin
      errors++;
      $display("FAIL br_lu: got %b expected 0011", {stall_pc, stall_ifid, flush_ifid, flush_idex});
    end
    @(negedge clk_i);
    ex_br_taken = 1'b0;
    #1;
    // Still in RUN, so the held load-use now stalls.
    checks++;
    if (stall_pc !== 1'b1) begin
      errors++; $display("FAIL br_state_run: got %b expected 1", stall_pc);
    end
    checks++;
    if (flush_cnt !== (PerfEn ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, PerfEn ? 1 : 0);
    end
  endtask

  task automatic test_dram_wait();
    reset_dut();
    mem_is_mem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_br_taken = (i == 1);
      #1;
      checks++;
      if ({stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex} !== 5'b11100) begin
        errors++;
        $display("FAIL wait_cycle%0d: got %b expected 11100", i,
                 {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex});
      end
      @(negedge clk_i);
    end
    mem_ready = 1'b1; ex_br_taken = 1'b1;
    #1;
    checks++;
    if ({stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex} !== 5'b00000) begin
      errors++;
      $display("FAIL wait_release: got %b expected 00000",
               {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex});
    end
    checks++;
    if (stall_cnt !== (PerfEn ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL wait_stall_cnt: got %0d expected %0d", stall_cnt, PerfEn ? 3 : 0);
    end
    @(negedge clk_i);
    ex_br_taken = 1'b0; mem_is_mem = 1'b0;
    set_load_use();
    #1;
    checks++;
    if (stall_pc !== 1'b1) begin
      errors++; $display("FAIL wait_back_to_run: got %b expected 1", stall_pc);
    end
  endtask

  task automatic test_reset_mid_bubble();
    reset_dut();
    set_load_use();
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_ctl: got %b expected 00000",
               {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex});
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cnt);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (fwd2_sel !== 2'b01 || stall_pc !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after: got fwd2=%b stall=%b expected 01/1", fwd2_sel, stall_pc);
    end
  endtask

  initial begin
    test_reset();
    test_raw_forward();
    test_priority();
    test_load_use();
    test_branch_vs_load_use();
    test_dram_wait();
    test_reset_mid_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
